pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter unit with a selectable next-PC source and an on-chip return-address stack.
//  Supports sequential increment, absolute jump, conditional PC-relative branch, call and return.
//  Sits between instruction decode (select/jumpAddr/offset/cond) and instruction fetch (PC).
//  Parametrised in address width and stack depth; adds stall and error reporting.
// PARAMETERS
//  WIDTH        16  address/PC width in bits
//  STACK_DEPTH  4   return-address stack entries (>=2)
//  RESET_PC     0   PC value loaded on reset
//  INC          1   sequential increment added to PC
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  stall        in   1      1 = hold PC, stack and flags; select ignored
//  select       in   3      next-PC mode (see BEHAVIOUR)
//  jumpAddr     in   WIDTH  absolute target for JUMP/CALL
//  offset       in   WIDTH  two's-complement branch displacement
//  cond         in   1      branch condition for BRANCH
//  PC           out  WIDTH  current program counter (registered)
//  redirect     out  1      1-cycle pulse: previous edge took a non-sequential transfer
//  stack_full   out  1      stack holds STACK_DEPTH entries (combinational from sp)
//  stack_empty  out  1      stack holds 0 entries (combinational from sp)
//  stack_err    out  1      sticky: overflow or underflow occurred since reset
// BEHAVIOUR
//  - Reset (any cycle, overrides stall/select): PC<=RESET_PC, sp<=0, redirect<=0, stack_err<=0.
//    Stack contents need not be cleared. stack_empty=1, stack_full=0 after reset.
//  - All updates occur on the rising clk edge when reset=0, stall=0; PC is valid that edge +0 (registered, 1-cycle latency from select to PC).
//  - select encoding (seq = PC+INC):
//    000 SEQ    PC<=seq; redirect<=0
//    001 JUMP   PC<=jumpAddr; redirect<=1
//    010 BRANCH cond=1: PC<=PC+offset, redirect<=1; cond=0: PC<=seq, redirect<=0
//    011 CALL   not full: stack[sp]<=seq, sp<=sp+1, PC<=jumpAddr, redirect<=1
//               full: no push, PC<=seq, redirect<=0, stack_err<=1
//    100 RET    not empty: PC<=stack[sp-1], sp<=sp-1, redirect<=1
//               empty: no pop, PC<=seq, redirect<=0, stack_err<=1
//    101-111    reserved: treated as SEQ
//  - Arithmetic modulo 2^WIDTH: PC+INC and PC+offset wrap silently, no flag.
//  - stall=1: PC, sp, stack, stack_err held; redirect<=0.
//  - stack_err clears only on reset.
//  - sp width = $clog2(STACK_DEPTH+1); LIFO order strict; one push or pop per cycle max.
// TESTING
//  1 reset then 3 SEQ cycles (WIDTH=16) -> PC 0x0000,0x0001,0x0002,0x0003; redirect=0; stack_empty=1.
//  2 PC=0x0080, JUMP jumpAddr=0x8808 -> next PC=0x8808, redirect=1 one cycle; BRANCH offset=0xFFF8 cond=1 -> PC=0x8800; cond=0 -> 0x8801.
//  3 PC=0xFFFF SEQ -> PC=0x0000, no error.
//  4 CALL 0x0100 from PC=0x0010, CALL 0x0200 from 0x0100, RET, RET -> PC 0x0100,0x0200,0x0101,0x0011; empty after.
//  5 5 CALLs with STACK_DEPTH=4 -> 5th: no push, PC=old+1, stack_full=1, stack_err=1; RET on empty -> PC+1, stack_err stays 1 until reset.
//  6 stall=1 with select=JUMP for 3 cycles -> PC/sp unchanged, redirect=0; reset asserted mid-stall -> PC=RESET_PC, sp=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC select (seq/jump/branch/call/ret) with a return-address stack.
// Latency 1 cycle select->PC; stall holds all state and drops redirect.
module pc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0,
    parameter int INC         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] jumpAddr,
    input  logic [WIDTH-1:0] offset,
    input  logic             cond,
    output logic [WIDTH-1:0] PC,
    output logic             redirect,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'b000,
        SEL_JUMP   = 3'b001,
        SEL_BRANCH = 3'b010,
        SEL_CALL   = 3'b011,
        SEL_RET    = 3'b100
    } sel_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             redirect_q, redirect_d;
    logic             stack_err_q, stack_err_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic [IDXW-1:0]  push_idx, pop_idx;
    logic             push_en;
    logic             full, empty;

    assign full     = (sp_q == SPW'(STACK_DEPTH));
    assign empty    = (sp_q == '0);
    assign seq_pc   = pc_q + WIDTH'(INC);
    assign push_idx = IDXW'(sp_q);
    assign pop_idx  = IDXW'(sp_q - SPW'(1));

    always_comb begin
        pc_d        = pc_q;
        sp_d        = sp_q;
        redirect_d  = 1'b0;
        stack_err_d = stack_err_q;
        push_en     = 1'b0;
        if (!stall) begin
            pc_d = seq_pc;
            case (select)
                SEL_JUMP: begin
                    pc_d       = jumpAddr;
                    redirect_d = 1'b1;
                end
                SEL_BRANCH: begin
                    if (cond) begin
                        pc_d       = pc_q + offset;
                        redirect_d = 1'b1;
                    end
                end
                SEL_CALL: begin
                    if (!full) begin
                        push_en    = 1'b1;
                        sp_d       = sp_q + SPW'(1);
                        pc_d       = jumpAddr;
                        redirect_d = 1'b1;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end
                SEL_RET: begin
                    if (!empty) begin
                        sp_d       = sp_q - SPW'(1);
                        pc_d       = stack_q[pop_idx];
                        redirect_d = 1'b1;
                    end else begin
                        stack_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= WIDTH'(RESET_PC);
            sp_q        <= '0;
            redirect_q  <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            redirect_q  <= redirect_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Stack storage carries no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack_q[push_idx] <= seq_pc;
        end
    end

    assign PC          = pc_q;
    assign redirect    = redirect_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus nested-call and sticky-error sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  select = 3'b000;
    logic [15:0] jumpAddr = '0;
    logic [15:0] offset = '0;
    logic        cond = 1'b0;
    logic [15:0] PC;
    logic        redirect, stack_full, stack_empty, stack_err;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer #(.WIDTH(16), .STACK_DEPTH(4), .RESET_PC(0), .INC(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .select(select),
        .jumpAddr(jumpAddr), .offset(offset), .cond(cond),
        .PC(PC), .redirect(redirect), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;

    typedef struct {
        string       name;
        logic        rst, stl;
        logic [2:0]  sel;
        logic [15:0] ja, off;
        logic        cnd;
        logic [15:0] pc;
        logic        rd, full, empty, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic rst, input logic stl, input logic [2:0] sel,
                       input logic [15:0] ja, input logic [15:0] off, input logic cnd,
                       input logic [15:0] pc, input logic rd, input logic full,
                       input logic empty, input logic err);
        vec_t v;
        v.name = nm; v.rst = rst; v.stl = stl; v.sel = sel; v.ja = ja; v.off = off;
        v.cnd = cnd; v.pc = pc; v.rd = rd; v.full = full; v.empty = empty; v.err = err;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic rst, input logic stl, input logic [2:0] sel,
                        input logic [15:0] ja, input logic [15:0] off, input logic cnd);
        @(negedge clk);
        reset = rst; stall = stl; select = sel; jumpAddr = ja; offset = off; cond = cnd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] pc, input logic rd,
                         input logic full, input logic empty, input logic err);
        n_checks++;
        if (PC === pc && redirect === rd && stack_full === full &&
            stack_empty === empty && stack_err === err) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc=%h rd=%b full=%b empty=%b err=%b, want pc=%h rd=%b full=%b empty=%b err=%b",
                     nm, PC, redirect, stack_full, stack_empty, stack_err, pc, rd, full, empty, err);
        end
    endtask

    logic [15:0] ret_q[$];
    logic [15:0] exp_pc;

    initial begin
        //   name          rst stl sel   ja       off      c  pc       rd full empty err
        add("reset",       1, 0, SEQ,  16'h0,   16'h0,   0, 16'h0000, 0, 0, 1, 0);
        add("seq1",        0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0001, 0, 0, 1, 0);
        add("seq2",        0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0002, 0, 0, 1, 0);
        add("seq3",        0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0003, 0, 0, 1, 0);
        add("jmp80",       0, 0, JMP,  16'h0080,16'h0,   0, 16'h0080, 1, 0, 1, 0);
        add("jmp8808",     0, 0, JMP,  16'h8808,16'h0,   0, 16'h8808, 1, 0, 1, 0);
        add("br_neg",      0, 0, BR,   16'h0,   16'hFFF8,1, 16'h8800, 1, 0, 1, 0);
        add("br_nt",       0, 0, BR,   16'h0,   16'hFFF8,0, 16'h8801, 0, 0, 1, 0);
        add("jmpffff",     0, 0, JMP,  16'hFFFF,16'h0,   0, 16'hFFFF, 1, 0, 1, 0);
        add("seq_wrap",    0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0000, 0, 0, 1, 0);
        add("rsv5",        0, 0, 3'd5, 16'h1234,16'h0,   1, 16'h0001, 0, 0, 1, 0);
        add("rsv7",        0, 0, 3'd7, 16'h1234,16'h0,   1, 16'h0002, 0, 0, 1, 0);
        add("jmp10",       0, 0, JMP,  16'h0010,16'h0,   0, 16'h0010, 1, 0, 1, 0);
        add("call100",     0, 0, CALL, 16'h0100,16'h0,   0, 16'h0100, 1, 0, 0, 0);
        add("call200",     0, 0, CALL, 16'h0200,16'h0,   0, 16'h0200, 1, 0, 0, 0);
        add("ret1",        0, 0, RET,  16'h0,   16'h0,   0, 16'h0101, 1, 0, 0, 0);
        add("ret2",        0, 0, RET,  16'h0,   16'h0,   0, 16'h0011, 1, 0, 1, 0);
        add("br_pos",      0, 0, BR,   16'h0,   16'h0004,1, 16'h0015, 1, 0, 1, 0);
        add("call_a",      0, 0, CALL, 16'h1000,16'h0,   0, 16'h1000, 1, 0, 0, 0);
        add("call_b",      0, 0, CALL, 16'h2000,16'h0,   0, 16'h2000, 1, 0, 0, 0);
        add("call_c",      0, 0, CALL, 16'h3000,16'h0,   0, 16'h3000, 1, 0, 0, 0);
        add("call_d",      0, 0, CALL, 16'h4000,16'h0,   0, 16'h4000, 1, 1, 0, 0);
        add("call_ovf",    0, 0, CALL, 16'h5000,16'h0,   0, 16'h4001, 0, 1, 0, 1);
        add("ret_d",       0, 0, RET,  16'h0,   16'h0,   0, 16'h3001, 1, 0, 0, 1);
        add("ret_c",       0, 0, RET,  16'h0,   16'h0,   0, 16'h2001, 1, 0, 0, 1);
        add("ret_b",       0, 0, RET,  16'h0,   16'h0,   0, 16'h1001, 1, 0, 0, 1);
        add("ret_a",       0, 0, RET,  16'h0,   16'h0,   0, 16'h0016, 1, 0, 1, 1);
        add("ret_unf",     0, 0, RET,  16'h0,   16'h0,   0, 16'h0017, 0, 0, 1, 1);
        add("seq_sticky",  0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0018, 0, 0, 1, 1);
        add("call400",     0, 0, CALL, 16'h0400,16'h0,   0, 16'h0400, 1, 0, 0, 1);
        add("stall1",      0, 1, JMP,  16'h7777,16'h0,   0, 16'h0400, 0, 0, 0, 1);
        add("stall2",      0, 1, JMP,  16'h7777,16'h0,   0, 16'h0400, 0, 0, 0, 1);
        add("stall3",      0, 1, JMP,  16'h7777,16'h0,   0, 16'h0400, 0, 0, 0, 1);
        add("stall_call",  0, 1, CALL, 16'h7777,16'h0,   0, 16'h0400, 0, 0, 0, 1);
        add("stall_ret",   0, 1, RET,  16'h0,   16'h0,   0, 16'h0400, 0, 0, 0, 1);
        add("rst_stall",   1, 1, JMP,  16'h7777,16'h0,   0, 16'h0000, 0, 0, 1, 0);
        add("post_rst",    0, 0, SEQ,  16'h0,   16'h0,   0, 16'h0001, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].sel, vecs[i].ja, vecs[i].off, vecs[i].cnd);
            check(vecs[i].name, vecs[i].pc, vecs[i].rd, vecs[i].full, vecs[i].empty, vecs[i].err);
        end

        // Nested calls to full depth, each interleaved with a SEQ, then unwind in LIFO order.
        exp_pc = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            ret_q.push_back(exp_pc + 16'h1);
            exp_pc = 16'h0A00 + 16'(i * 16'h0040);
            step(0, 0, CALL, exp_pc, 16'h0, 0);
            check("nest_call", exp_pc, 1, (i == 3), 0, 0);
            step(0, 0, SEQ, 16'h0, 16'h0, 0);
            exp_pc = exp_pc + 16'h1;
            check("nest_seq", exp_pc, 0, (i == 3), 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_pc = ret_q.pop_back();
            step(0, 0, RET, 16'h0, 16'h0, 0);
            check("nest_ret", exp_pc, 1, 0, (i == 3), 0);
        end

        // Underflow sets the sticky flag; it survives stalls and later traffic until reset.
        step(0, 0, RET, 16'h0, 16'h0, 0);
        exp_pc = exp_pc + 16'h1;
        check("unf_err", exp_pc, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, (i % 2 == 1), (i % 2 == 1) ? RET : SEQ, 16'h0, 16'h0, 0);
            if (i % 2 == 0) exp_pc = exp_pc + 16'h1;
            check("err_hold", exp_pc, 0, 0, 1, 1);
        end
        step(0, 0, CALL, 16'h0300, 16'h0, 0);
        check("err_call", 16'h0300, 1, 0, 0, 1);
        step(1, 0, SEQ, 16'h0, 16'h0, 0);
        check("err_clear", 16'h0000, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
